// File: rtl/arm7tdmi_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches and queues {instr, pc}
// pairs for decode. A flush empties the queue and restarts fetching at a new PC.
module arm7tdmi_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        halt,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];

  logic          w_accept;
  logic          w_pop;
  logic          w_room;
  logic [CW-1:0] w_count_next;
  logic          w_unused_flush_pc_lsbs;

  // Flush wins over an in-flight response: its data is dropped and no pop is taken.
  assign w_accept     = (r_state == REQ) & mem_ready & ~flush;
  assign instr_valid  = (r_count != '0) & ~flush;
  assign w_pop        = instr_valid & instr_ready;
  assign w_count_next = r_count + CW'(w_accept) - CW'(w_pop);
  assign w_room       = (w_count_next < FULL);

  assign w_unused_flush_pc_lsbs = ^flush_pc[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: w_state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (!halt && w_room) w_state_next = REQ;
        REQ:     if (w_accept) w_state_next = (!halt && w_room) ? REQ : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Request outputs come straight from registers; no path from mem_ready.
  always_comb begin
    mem_re   = (r_state == REQ);
    mem_addr = r_fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (flush) begin
      r_fetch_pc <= {flush_pc[31:2], 2'b00};
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // NOTE: the entry storage is deliberately not reset; r_count alone decides which
  // entries are live, and leaving reset off lets the array map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fifo_instr[r_wr_ptr] <= mem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign instr    = r_fifo_instr[r_rd_ptr];
  assign instr_pc = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_arm7tdmi_prefetch_buffer.sv
// Self-checking bench for arm7tdmi_prefetch_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_arm7tdmi_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halt;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_checks = 0;
  int n_fail   = 0;

  arm7tdmi_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .halt        (halt),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // Reference model: the queue of fetched words, whether a fetch is outstanding,
  // and the address that fetch is for.
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t      m_q[$];
  bit          m_fetching;
  logic [31:0] m_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE3A0_1010;
      32'h0000_0004: return 32'hE3A0_2020;
      32'h0000_0008: return 32'hE081_3002;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  function automatic void model_update();
    bit acc;
    bit pop;
    if (!rst_n) begin
      m_q.delete();
      m_fetching = 1'b0;
      m_pc       = RESET_PC;
      return;
    end
    if (flush) begin
      m_q.delete();
      m_fetching = 1'b0;
      m_pc       = {flush_pc[31:2], 2'b00};
      return;
    end
    acc = m_fetching && mem_ready;
    pop = (m_q.size() != 0) && instr_ready;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back('{word: mem_word(m_pc), pc: m_pc});
      m_pc = m_pc + 32'd4;
    end
    // A new fetch may start only when nothing is outstanding and there is room.
    if (!m_fetching || acc) m_fetching = !halt && (m_q.size() < DEPTH);
  endfunction

  // Drive one cycle's inputs (away from the edge) and compare outputs to the model.
  task automatic drive(input logic r, input logic f, input logic [31:0] fpc,
                       input logic h, input logic rdy, input logic ir);
    logic exp_valid;
    rst_n       = r;
    flush       = f;
    flush_pc    = fpc;
    halt        = h;
    mem_ready   = rdy;
    instr_ready = ir;
    mem_rdata   = rdy ? mem_word(mem_addr) : $urandom;
    #1;
    exp_valid = (m_q.size() != 0) && !f;
    check("mem_re", {31'd0, mem_re}, {31'd0, m_fetching});
    check("mem_addr", mem_addr, m_pc);
    check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("instr", instr, m_q[0].word);
      check("instr_pc", instr_pc, m_q[0].pc);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          n_acc;
    int          w;
    logic        rdy;
    logic [31:0] prev_addr;

    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; halt = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_q.delete();
    m_fetching = 1'b0;
    m_pc       = RESET_PC;

    // Reset state
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("reset_mem_re", {31'd0, mem_re}, 32'd0);
    check("reset_mem_addr", mem_addr, RESET_PC);
    check("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
    tick();

    // Sequential fetch with zero-wait memory
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("seq_c0_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("seq_c1_mem_re", {31'd0, mem_re}, 32'd1);
    check("seq_c1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("seq_c2_valid", {31'd0, instr_valid}, 32'd1);
    check("seq_c2_instr", instr, 32'hE3A0_1010);
    check("seq_c2_pc", instr_pc, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("seq_c3_instr", instr, 32'hE3A0_2020);
    check("seq_c3_pc", instr_pc, 32'h4);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("seq_c4_instr", instr, 32'hE081_3002);
    check("seq_c4_pc", instr_pc, 32'h8);
    tick();

    // Backpressure: queue fills to DEPTH, then fetching stops at 0x10
    drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (mem_re && mem_ready) n_acc++;
      tick();
    end
    check("bp_accepts", n_acc, 32'd4);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("bp_full_mem_re", {31'd0, mem_re}, 32'd0);
    check("bp_full_addr", mem_addr, 32'h10);
    check("bp_head_pc", instr_pc, 32'h0);
    tick();
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (mem_re && mem_ready) begin
        n_acc++;
        check("bp_refill_addr", mem_addr, 32'h10);
      end
      tick();
    end
    check("bp_refill_accepts", n_acc, 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("bp_after_addr", mem_addr, 32'h14);
    check("bp_after_mem_re", {31'd0, mem_re}, 32'd0);
    tick();

    // Wait states: ready three cycles after each request starts
    drive(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    tick();
    n_acc = 0;
    w = 0;
    prev_addr = '0;
    for (int i = 0; i < 20; i++) begin
      rdy = mem_re && (w == 3);
      drive(1'b1, 1'b0, 32'h0, 1'b0, rdy, 1'b1);
      if (mem_re && w > 0) check("ws_addr_stable", mem_addr, prev_addr);
      if (mem_re && mem_ready) begin
        n_acc++;
        w = 0;
      end else if (mem_re) begin
        w++;
      end
      prev_addr = mem_addr;
      tick();
    end
    check("ws_accepts", n_acc, 32'd4);

    // Flush while a request to 0x8 is pending and answered in the same cycle
    drive(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("fl_pending_addr", mem_addr, 32'h8);
    check("fl_pending_re", {31'd0, mem_re}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0107, 1'b0, 1'b1, 1'b0);
    check("fl_cycle_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("fl_next_valid", {31'd0, instr_valid}, 32'd0);
    check("fl_next_mem_re", {31'd0, mem_re}, 32'd0);
    check("fl_next_addr", mem_addr, 32'h104);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("fl_req_mem_re", {31'd0, mem_re}, 32'd1);
    check("fl_req_addr", mem_addr, 32'h104);
    tick();

    // Halt with two entries queued and a request pending
    drive(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("halt_pending_re", {31'd0, mem_re}, 32'd1);
    check("halt_pending_addr", mem_addr, 32'h208);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("halt_complete_re", {31'd0, mem_re}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      check("halt_drain_re", {31'd0, mem_re}, 32'd0);
      check("halt_drain_valid", {31'd0, instr_valid}, 32'd1);
      check("halt_drain_pc", instr_pc, 32'h200 + 32'(4 * i));
      tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("halt_empty_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_empty_re", {31'd0, mem_re}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("halt_release_re", {31'd0, mem_re}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("halt_resume_re", {31'd0, mem_re}, 32'd1);
    check("halt_resume_addr", mem_addr, 32'h20C);
    tick();

    // Address wrap past 0xFFFFFFFC
    drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("wrap_re", {31'd0, mem_re}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    check("wrap_addr_zero", mem_addr, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("wrap_pc2", instr_pc, 32'h0);
    tick();

    // Random traffic, including occasional flushes and mid-request resets
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(15) == 0), $urandom,
            ($urandom_range(3) == 0), ($urandom_range(1) == 1), ($urandom_range(1) == 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
